// File: rtl/trial_factor_ctrl.sv
// Trial-factoring controller: computes 2^p mod q by left-to-right square-and-double,
// sharing an external modulo unit for the squaring step.
module trial_factor_ctrl #(
   parameter int unsigned BITWIDTH = 32,
   parameter int unsigned EXPWIDTH = 32
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst_n,
   input  logic                  start,
   input  logic [EXPWIDTH-1:0]   exponent,
   input  logic [BITWIDTH-1:0]   candidate,
   output logic                  busy,
   output logic                  done,
   output logic                  is_factor,
   output logic [BITWIDTH-1:0]   residue,
   output logic                  err,
   output logic                  div_start,
   output logic [2*BITWIDTH-1:0] div_numerator,
   output logic [2*BITWIDTH-1:0] div_denominator,
   input  logic [2*BITWIDTH-1:0] div_remainder,
   input  logic                  div_finished
);

   localparam int unsigned IdxW = (EXPWIDTH > 1) ? $clog2(EXPWIDTH) : 1;
   localparam logic [IdxW-1:0] IdxTop = IdxW'(EXPWIDTH - 1);

   typedef enum logic [2:0] {
      StIdle, StCheck, StSkip, StSquare, StWaitDiv, StDouble, StNext, StFinish
   } state_e;

   state_e               state_q, state_d;
   logic [EXPWIDTH-1:0]  p_q, p_d;
   logic [BITWIDTH-1:0]  q_q, q_d;
   logic [BITWIDTH-1:0]  r_q, r_d;
   logic [BITWIDTH-1:0]  residue_q, residue_d;
   logic [IdxW-1:0]      idx_q, idx_d;
   logic                 guard_q, guard_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 err_q, err_d;
   logic                 is_factor_q, is_factor_d;
   logic                 div_start_q, div_start_d;
   logic [BITWIDTH:0]    dbl;
   logic                 p_bit;

   assign p_bit = p_q[idx_q];
   assign dbl   = {r_q, 1'b0};

   always_comb begin
      state_d     = state_q;
      p_d         = p_q;
      q_d         = q_q;
      r_d         = r_q;
      residue_d   = residue_q;
      idx_d       = idx_q;
      guard_d     = guard_q;
      err_d       = err_q;
      is_factor_d = is_factor_q;
      done_d      = 1'b0;
      div_start_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               p_d         = exponent;
               q_d         = candidate;
               r_d         = BITWIDTH'(1);
               idx_d       = IdxTop;
               err_d       = 1'b0;
               is_factor_d = 1'b0;
               residue_d   = '0;
               state_d     = StCheck;
            end
         end
         StCheck: begin
            if (q_q < BITWIDTH'(2) || p_q < EXPWIDTH'(2)) begin
               err_d       = 1'b1;
               residue_d   = '0;
               is_factor_d = 1'b0;
               done_d      = 1'b1;
               state_d     = StFinish;
            end else begin
               state_d = StSkip;
            end
         end
         StSkip: begin
            // p >= 2 guarantees a leading one before the index runs out
            if (p_bit) begin
               div_start_d = 1'b1;
               state_d     = StSquare;
            end else begin
               idx_d = idx_q - 1'b1;
            end
         end
         StSquare: begin
            guard_d = 1'b1;
            state_d = StWaitDiv;
         end
         StWaitDiv: begin
            // First cycle is a guard: the unit's finished flag may still be stale
            if (guard_q) begin
               guard_d = 1'b0;
            end else if (div_finished) begin
               r_d     = div_remainder[BITWIDTH-1:0];
               state_d = p_bit ? StDouble : StNext;
            end
         end
         StDouble: begin
            r_d     = (dbl >= {1'b0, q_q}) ? BITWIDTH'(dbl - {1'b0, q_q}) : BITWIDTH'(dbl);
            state_d = StNext;
         end
         StNext: begin
            if (idx_q == '0) begin
               residue_d   = r_q;
               is_factor_d = (r_q == BITWIDTH'(1));
               done_d      = 1'b1;
               state_d     = StFinish;
            end else begin
               idx_d       = idx_q - 1'b1;
               div_start_d = 1'b1;
               state_d     = StSquare;
            end
         end
         StFinish: state_d = StIdle;
         default:  state_d = StIdle;
      endcase
      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q     <= StIdle;
         p_q         <= '0;
         q_q         <= '0;
         r_q         <= '0;
         residue_q   <= '0;
         idx_q       <= '0;
         guard_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         is_factor_q <= 1'b0;
         div_start_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         p_q         <= p_d;
         q_q         <= q_d;
         r_q         <= r_d;
         residue_q   <= residue_d;
         idx_q       <= idx_d;
         guard_q     <= guard_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
         is_factor_q <= is_factor_d;
         div_start_q <= div_start_d;
      end
   end

   assign busy            = busy_q;
   assign done            = done_q;
   assign err             = err_q;
   assign is_factor       = is_factor_q;
   assign residue         = residue_q;
   assign div_start       = div_start_q;
   // r only changes on remainder load or doubling, so the operands hold while dividing
   assign div_numerator   = {{BITWIDTH{1'b0}}, r_q} * {{BITWIDTH{1'b0}}, r_q};
   assign div_denominator = {{BITWIDTH{1'b0}}, q_q};

endmodule

// File: tb/tb_trial_factor_ctrl.sv
// Bench for trial_factor_ctrl: directed scenarios plus randomized trials checked
// against a repeated-doubling model of 2^p mod q, with a behavioural modulo unit.
module tb_trial_factor_ctrl;

   localparam int unsigned BW = 8;
   localparam int unsigned EW = 12;

   logic            sys_clk = 1'b0;
   logic            sys_rst_n = 1'b0;
   logic            start = 1'b0;
   logic [EW-1:0]   exponent = '0;
   logic [BW-1:0]   candidate = '0;
   logic            busy, done, is_factor, err, div_start;
   logic [BW-1:0]   residue;
   logic [2*BW-1:0] div_numerator, div_denominator;
   logic [2*BW-1:0] div_remainder;
   logic            div_finished;

   int checks = 0;
   int errors = 0;

   trial_factor_ctrl #(.BITWIDTH(BW), .EXPWIDTH(EW)) dut (
      .sys_clk         (sys_clk),
      .sys_rst_n       (sys_rst_n),
      .start           (start),
      .exponent        (exponent),
      .candidate       (candidate),
      .busy            (busy),
      .done            (done),
      .is_factor       (is_factor),
      .residue         (residue),
      .err             (err),
      .div_start       (div_start),
      .div_numerator   (div_numerator),
      .div_denominator (div_denominator),
      .div_remainder   (div_remainder),
      .div_finished    (div_finished)
   );

   always #5 sys_clk = ~sys_clk;

   // Behavioural modulo unit with random latency and garbage in the ignored upper half
   logic [2*BW-1:0] m_num, m_den;
   int              m_lat;
   int              ds_count = 0;
   int              stab_bad = 0;
   int              big_bad = 0;
   int unsigned     cur_q = 0;

   always @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         div_finished  <= 1'b1;
         div_remainder <= '0;
         m_lat         <= 0;
      end else if (div_start) begin
         m_num        <= div_numerator;
         m_den        <= div_denominator;
         m_lat        <= int'($urandom_range(1, 5));
         div_finished <= 1'b0;
         ds_count     <= ds_count + 1;
         if (32'(div_numerator) > (cur_q - 1) * (cur_q - 1)) big_bad <= big_bad + 1;
      end else if (!div_finished) begin
         if (div_numerator !== m_num || div_denominator !== m_den) stab_bad <= stab_bad + 1;
         if (m_lat <= 1) begin
            div_finished  <= 1'b1;
            div_remainder <= {8'($urandom), 8'(m_num % m_den)};
         end else begin
            m_lat <= m_lat - 1;
         end
      end
   end

   function automatic void ref_model(input int unsigned p, input int unsigned q,
                                     output int unsigned res, output bit isf,
                                     output bit er, output int nds);
      res = 0; isf = 0; er = 1; nds = 0;
      if (p < 2 || q < 2) return;
      er  = 0;
      res = 1;
      for (int i = 0; i < int'(p); i++) res = (res * 2) % q;
      isf = (res == 1);
      for (int unsigned x = p; x != 0; x = x >> 1) nds++;
   endfunction

   task automatic run_trial(input int unsigned p, input int unsigned q,
                            output int unsigned res, output bit isf, output bit er,
                            output int lat, output int nds, output bit to);
      int c0;
      c0    = ds_count;
      cur_q = q;
      @(negedge sys_clk);
      exponent  = EW'(p);
      candidate = BW'(q);
      start     = 1'b1;
      @(negedge sys_clk);
      start = 1'b0;
      lat   = 1;
      to    = 1'b1;
      for (int i = 0; i < 2000; i++) begin
         if (done) begin
            to = 1'b0;
            break;
         end
         @(negedge sys_clk);
         lat++;
      end
      res = residue;
      isf = is_factor;
      er  = err;
      nds = ds_count - c0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge sys_clk);
      checks++;
      if ({busy, done, div_start, err, is_factor, residue, div_numerator} !== '0) begin
         errors++;
         $display("FAIL reset_state got busy=%b done=%b ds=%b err=%b isf=%b res=%0d num=%0d want all 0",
                  busy, done, div_start, err, is_factor, residue, div_numerator);
      end
      sys_rst_n = 1'b1;
      @(negedge sys_clk);
   endtask

   task automatic test_known();
      int unsigned res; bit isf, er, to; int lat, nds, b0, s0;
      b0 = big_bad; s0 = stab_bad;
      run_trial(11, 23, res, isf, er, lat, nds, to);
      checks++;
      if (to || {res, isf, er} !== {32'd1, 1'b1, 1'b0} || nds != 4) begin
         errors++;
         $display("FAIL p11_q23 got res=%0d isf=%b err=%b ds=%0d to=%b want res=1 isf=1 err=0 ds=4",
                  res, isf, er, nds, to);
      end
      @(negedge sys_clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || residue !== 8'd1 || is_factor !== 1'b1) begin
         errors++;
         $display("FAIL done_pulse_hold got done=%b busy=%b res=%0d isf=%b want 0 0 1 1",
                  done, busy, residue, is_factor);
      end
      run_trial(11, 13, res, isf, er, lat, nds, to);
      checks++;
      if (to || {res, isf, er} !== {32'd7, 1'b0, 1'b0} || nds != 4) begin
         errors++;
         $display("FAIL p11_q13 got res=%0d isf=%b err=%b ds=%0d to=%b want res=7 isf=0 err=0 ds=4",
                  res, isf, er, nds, to);
      end
      checks++;
      if (big_bad != b0 || stab_bad != s0) begin
         errors++;
         $display("FAIL known_operands got big=%0d stab=%0d want big=%0d stab=%0d",
                  big_bad, stab_bad, b0, s0);
      end
   endtask

   task automatic test_mersenne7();
      int unsigned res; bit isf, er, to; int lat, nds, b0;
      b0 = big_bad;
      run_trial(7, 127, res, isf, er, lat, nds, to);
      checks++;
      if (to || {res, isf, er} !== {32'd1, 1'b1, 1'b0} || nds != 3) begin
         errors++;
         $display("FAIL p7_q127 got res=%0d isf=%b err=%b ds=%0d to=%b want res=1 isf=1 err=0 ds=3",
                  res, isf, er, nds, to);
      end
      checks++;
      if (big_bad != b0) begin
         errors++;
         $display("FAIL p7_q127_num_bound got %0d oversize numerators want 0", big_bad - b0);
      end
   endtask

   task automatic test_errors();
      int unsigned res; bit isf, er, to; int lat, nds;
      int unsigned ps[4] = '{11, 1, 0, 5};
      int unsigned qs[4] = '{1, 23, 7, 0};
      for (int i = 0; i < 4; i++) begin
         run_trial(ps[i], qs[i], res, isf, er, lat, nds, to);
         checks++;
         if (to || {res, isf, er} !== {32'd0, 1'b0, 1'b1} || nds != 0 || lat > 4) begin
            errors++;
            $display("FAIL reject_p%0d_q%0d got res=%0d isf=%b err=%b ds=%0d lat=%0d want 0 0 1 ds=0 lat<=4",
                     ps[i], qs[i], res, isf, er, nds, lat);
         end
      end
   endtask

   task automatic test_start_while_busy();
      int c0; bit seen, fin;
      c0 = ds_count; cur_q = 23;
      @(negedge sys_clk);
      exponent = 12'd11; candidate = 8'd23; start = 1'b1;
      @(negedge sys_clk);
      start = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
         if (div_start) seen = 1'b1;
         else @(negedge sys_clk);
      end
      @(negedge sys_clk);
      exponent = 12'd5; candidate = 8'd3; start = 1'b1;
      @(negedge sys_clk);
      start = 1'b0;
      fin = 1'b0;
      for (int i = 0; i < 500 && !fin; i++) begin
         if (done) fin = 1'b1;
         else @(negedge sys_clk);
      end
      checks++;
      if (!seen || !fin || residue !== 8'd1 || is_factor !== 1'b1 || err !== 1'b0
          || ds_count - c0 != 4) begin
         errors++;
         $display("FAIL start_while_busy got fin=%b res=%0d isf=%b err=%b ds=%0d want res=1 isf=1 err=0 ds=4",
                  fin, residue, is_factor, err, ds_count - c0);
      end
      // done cycle is FINISH: a start here must be ignored
      exponent = 12'd5; candidate = 8'd3; start = 1'b1;
      @(negedge sys_clk);
      start = 1'b0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL start_in_finish got busy=%b done=%b want busy=0 done=0", busy, done);
      end
   endtask

   task automatic test_reset_mid();
      int unsigned res; bit isf, er, to, bad_done; int lat, nds, n;
      cur_q = 23;
      @(negedge sys_clk);
      exponent = 12'd11; candidate = 8'd23; start = 1'b1;
      @(negedge sys_clk);
      start = 1'b0;
      n = 0;
      for (int i = 0; i < 200 && n < 2; i++) begin
         if (div_start) n++;
         if (n < 2) @(negedge sys_clk);
      end
      @(negedge sys_clk);
      sys_rst_n = 1'b0;
      #1;
      checks++;
      if (n != 2 || {busy, done, div_start, err, is_factor, residue} !== '0) begin
         errors++;
         $display("FAIL reset_mid_clear got n=%0d busy=%b done=%b ds=%b err=%b isf=%b res=%0d want all 0",
                  n, busy, done, div_start, err, is_factor, residue);
      end
      bad_done = 1'b0;
      repeat (2) @(negedge sys_clk);
      sys_rst_n = 1'b1;
      repeat (5) begin
         @(negedge sys_clk);
         if (done) bad_done = 1'b1;
      end
      checks++;
      if (bad_done) begin
         errors++;
         $display("FAIL reset_mid_no_done got done pulse after reset want none");
      end
      run_trial(11, 13, res, isf, er, lat, nds, to);
      checks++;
      if (to || {res, isf, er} !== {32'd7, 1'b0, 1'b0} || nds != 4) begin
         errors++;
         $display("FAIL after_reset_p11_q13 got res=%0d isf=%b err=%b ds=%0d want res=7 isf=0 err=0 ds=4",
                  res, isf, er, nds);
      end
   endtask

   task automatic test_random();
      int unsigned p, q, res, eres; bit isf, er, eisf, eer, to; int lat, nds, ends, b0, s0;
      for (int t = 0; t < 40; t++) begin
         p = (t % 8 == 0) ? $urandom_range(0, 3) : $urandom_range(0, (1 << EW) - 1);
         q = (t % 7 == 0) ? $urandom_range(0, 2) : $urandom_range(0, (1 << BW) - 1);
         ref_model(p, q, eres, eisf, eer, ends);
         b0 = big_bad; s0 = stab_bad;
         run_trial(p, q, res, isf, er, lat, nds, to);
         checks++;
         if (to || res != eres || isf !== eisf || er !== eer || nds != ends
             || big_bad != b0 || stab_bad != s0) begin
            errors++;
            $display("FAIL random_p%0d_q%0d got res=%0d isf=%b err=%b ds=%0d big=%0d stab=%0d to=%b want res=%0d isf=%b err=%b ds=%0d",
                     p, q, res, isf, er, nds, big_bad - b0, stab_bad - s0, to,
                     eres, eisf, eer, ends);
         end
      end
   endtask

   initial begin
      test_reset();
      test_known();
      test_mersenne7();
      test_errors();
      test_start_while_busy();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
